// File: rtl/mac_pkg.sv
// Shared constants, saturation-bound helper and stage record for the mac_pipe slice.
package mac_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_ACC_WIDTH = 40;
    localparam int DEF_CNT_WIDTH = 16;
    localparam int BOUND_W       = 128;

    // Largest (neg=0) or smallest (neg=1) signed value representable in w bits.
    function automatic logic signed [BOUND_W-1:0] sat_bound(input int w, input logic neg);
        logic signed [BOUND_W-1:0] one;
        one = BOUND_W'(1);
        return neg ? -(one <<< (w - 1)) : (one <<< (w - 1)) - one;
    endfunction

    typedef struct packed {
        logic signed [DEF_WIDTH-1:0]   a;
        logic signed [DEF_WIDTH-1:0]   b;
        logic signed [2*DEF_WIDTH-1:0] prod;
        logic                          last;
        logic                          vld;
    } mac_stage_t;

endpackage

// File: rtl/mac_pipe_wallace_mult.sv
// wallace_mult: combinational signed WIDTH x WIDTH multiplier, partial products reduced by 3:2 carry-save layers.
module wallace_mult
    import mac_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic signed [WIDTH-1:0]   i_a,
    input  logic signed [WIDTH-1:0]   i_b,
    output logic signed [2*WIDTH-1:0] o_p
);

    localparam int PW = 2 * WIDTH;
    localparam int NR = WIDTH + 1;

    logic [PW-1:0] w_a_ext;
    logic [PW-1:0] w_rows [NR];
    logic [PW-1:0] w_next [NR];
    int            w_n;
    int            w_m;

    assign w_a_ext = PW'(i_a);

    always_comb begin
        w_rows = '{default: '0};
        w_next = '{default: '0};
        w_m    = 0;
        for (int i = 0; i < WIDTH - 1; i++)
            w_rows[i] = i_b[i] ? (w_a_ext << i) : '0;
        // The sign bit of b has negative weight: add ~(a<<(W-1)) plus a separate +1 row.
        w_rows[WIDTH-1] = i_b[WIDTH-1] ? ~(w_a_ext << (WIDTH - 1)) : '0;
        w_rows[WIDTH]   = PW'(i_b[WIDTH-1]);
        w_n = NR;
        for (int lvl = 0; lvl < NR; lvl++) begin
            if (w_n > 2) begin
                w_next = '{default: '0};
                w_m    = 0;
                for (int i = 0; i + 2 < NR; i += 3) begin
                    if (i + 2 < w_n) begin
                        w_next[w_m]   = w_rows[i] ^ w_rows[i+1] ^ w_rows[i+2];
                        w_next[w_m+1] = ((w_rows[i] & w_rows[i+1]) | (w_rows[i] & w_rows[i+2]) |
                                         (w_rows[i+1] & w_rows[i+2])) << 1;
                        w_m += 2;
                    end
                end
                for (int i = 0; i < NR; i++) begin
                    if (i >= (w_n / 3) * 3 && i < w_n) begin
                        w_next[w_m] = w_rows[i];
                        w_m += 1;
                    end
                end
                w_rows = w_next;
                w_n    = w_m;
            end
        end
        o_p = signed'(w_rows[0] + w_rows[1]);
    end

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: 3-stage pipelined signed MAC with grouped results under valid/ready.
// Build option: define MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     in_a,
    input  logic signed [WIDTH-1:0]     in_b,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_acc,
    output logic [CNT_WIDTH-1:0]        out_count,
    output logic                        out_ovf
);

`ifdef MAC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_bound(ACC_WIDTH, 1'b0));
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_bound(ACC_WIDTH, 1'b1));
`endif

    // Returns {sticky overflow, next accumulator}.
    function automatic logic [ACC_WIDTH:0] acc_step(input logic signed [ACC_WIDTH-1:0] acc,
                                                    input logic signed [ACC_WIDTH-1:0] addend,
                                                    input logic                        ovf_in);
        logic signed [ACC_WIDTH-1:0] sum;
        logic                        ovf;
        sum = acc + addend;
        ovf = (acc[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
`ifdef MAC_SATURATE_EN
        if (ovf_in)
            sum = acc;
        else if (ovf)
            sum = acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
`endif
        return {ovf_in | ovf, sum};
    endfunction

    logic                        w_adv;
    logic signed [2*WIDTH-1:0]   w_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic [ACC_WIDTH:0]          w_step;

    logic                        r_vld_p0, r_vld_p1;
    logic signed [WIDTH-1:0]     r_a_p0, r_b_p0;
    logic                        r_last_p0, r_last_p1;
    logic signed [2*WIDTH-1:0]   r_prod_p1;
    logic signed [ACC_WIDTH-1:0] r_acc_p2;
    logic [CNT_WIDTH-1:0]        r_cnt_p2;
    logic                        r_ovf_p2;
    logic                        r_out_valid;
    logic signed [ACC_WIDTH-1:0] r_out_acc;
    logic [CNT_WIDTH-1:0]        r_out_count;
    logic                        r_out_ovf;

    assign in_ready   = !(r_out_valid && !out_ready);
    assign w_adv      = in_ready;
    assign w_prod_ext = ACC_WIDTH'(r_prod_p1);
    assign w_step     = acc_step(r_acc_p2, w_prod_ext, r_ovf_p2);

    assign out_valid  = r_out_valid;
    assign out_acc    = r_out_acc;
    assign out_count  = r_out_count;
    assign out_ovf    = r_out_ovf;

    wallace_mult #(.WIDTH(WIDTH)) u_mult (
        .i_a (r_a_p0),
        .i_b (r_b_p0),
        .o_p (w_prod)
    );

    // S1 / S2 datapath: operands, then product
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_a_p0    <= in_a;
            r_b_p0    <= in_b;
            r_last_p0 <= in_last;
            r_prod_p1 <= w_prod;
            r_last_p1 <= r_last_p0;
        end
    end

    // S3: accumulate, close groups into the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0    <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_acc_p2    <= '0;
            r_cnt_p2    <= '0;
            r_ovf_p2    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            if (w_adv) begin
                r_vld_p0 <= in_valid;
                r_vld_p1 <= r_vld_p0;
                if (r_vld_p1) begin
                    if (r_last_p1) begin
                        r_out_acc   <= w_step[ACC_WIDTH-1:0];
                        r_out_count <= r_cnt_p2 + CNT_WIDTH'(1);
                        r_out_ovf   <= w_step[ACC_WIDTH];
                        r_acc_p2    <= '0;
                        r_cnt_p2    <= '0;
                        r_ovf_p2    <= 1'b0;
                    end else begin
                        r_acc_p2    <= w_step[ACC_WIDTH-1:0];
                        r_cnt_p2    <= r_cnt_p2 + CNT_WIDTH'(1);
                        r_ovf_p2    <= w_step[ACC_WIDTH];
                    end
                end
            end
            if (w_adv && r_vld_p1 && r_last_p1)
                r_out_valid <= 1'b1;
            else if (out_ready)
                r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// Self-checking bench for mac_pipe: directed steps plus randomized traffic against a group-level reference model.
`timescale 1ns/1ps
module tb_mac_pipe;

`ifdef MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        longint acc;
        longint cnt;
        bit     ovf;
    } res_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic               out_ready = 1'b0;
    logic signed [15:0] in_a = '0;
    logic signed [15:0] in_b = '0;
    logic               in_ready, in_ready32;
    logic               out_valid, out_valid32;
    logic               out_ovf, out_ovf32;
    logic signed [39:0] out_acc;
    logic signed [31:0] out_acc32;
    logic [15:0]        out_count, out_count32;

    int     n_cmp = 0;
    int     n_fail = 0;
    res_t   q40[$];
    res_t   q32[$];
    longint g_acc40 = 0, g_acc32 = 0, g_cnt = 0;
    bit     g_ovf40 = 0, g_ovf32 = 0;
    res_t   m_e;
    longint m_p;

    always #5 clk = ~clk;

    mac_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
    );

    mac_pipe #(.ACC_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_acc(out_acc32), .out_count(out_count32), .out_ovf(out_ovf32)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Group sum as true integer arithmetic, then range-checked against a w-bit signed accumulator.
    task automatic model_add(inout longint acc, inout bit ovf, input longint p, input int w);
        longint hi, lo, s;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (SAT && ovf)
            return;
        s = acc + p;
        if (s > hi || s < lo) begin
            ovf = 1'b1;
            if (SAT)
                acc = (s > hi) ? hi : lo;
            else
                acc = (s > hi) ? s - (longint'(1) <<< w) : s + (longint'(1) <<< w);
        end else begin
            acc = s;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            g_acc40 = 0; g_acc32 = 0; g_cnt = 0; g_ovf40 = 0; g_ovf32 = 0;
            q40.delete();
            q32.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q40.size() == 0)
                    check("sb40_unexpected_valid", out_valid, 1'b0);
                else begin
                    m_e = q40.pop_front();
                    check("sb40_acc", out_acc, m_e.acc);
                    check("sb40_count", out_count, m_e.cnt);
                    check("sb40_ovf", out_ovf, m_e.ovf);
                end
            end
            if (out_valid32 && out_ready) begin
                if (q32.size() == 0)
                    check("sb32_unexpected_valid", out_valid32, 1'b0);
                else begin
                    m_e = q32.pop_front();
                    check("sb32_acc", out_acc32, m_e.acc);
                    check("sb32_count", out_count32, m_e.cnt);
                    check("sb32_ovf", out_ovf32, m_e.ovf);
                end
            end
            if (in_valid && in_ready) begin
                m_p = longint'(in_a) * longint'(in_b);
                model_add(g_acc40, g_ovf40, m_p, 40);
                model_add(g_acc32, g_ovf32, m_p, 32);
                g_cnt++;
                if (in_last) begin
                    q40.push_back('{g_acc40, g_cnt % 65536, g_ovf40});
                    q32.push_back('{g_acc32, g_cnt % 65536, g_ovf32});
                    g_acc40 = 0; g_acc32 = 0; g_cnt = 0; g_ovf40 = 0; g_ovf32 = 0;
                end
            end
        end
    end

    task automatic send(input logic signed [15:0] a, input logic signed [15:0] b, input logic last);
        int   n;
        logic ok;
        n = 0;
        ok = 1'b0;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        in_valid = 1'b0;
        check("send_accepted", ok, 1'b1);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 50);
        check("out_valid_seen", out_valid, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic signed [15:0] pick();
        case ($urandom_range(7))
            0:       return -16'sd32768;
            1:       return 16'sd32767;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic pend;
        logic ok;

        rst = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_valid32", out_valid32, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_acc", out_acc, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_ovf", out_ovf, 1'b0);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);

        send(16'sd3, 16'sd4, 1'b1);
        check("lat_edge_k", out_valid, 1'b0);
        idle(1);
        check("lat_edge_k1", out_valid, 1'b0);
        idle(1);
        check("lat_edge_k2", out_valid, 1'b1);
        check("single_acc", out_acc, 12);
        check("single_count", out_count, 1);
        check("single_ovf", out_ovf, 1'b0);
        idle(2);

        send(16'sd1, 16'sd2, 1'b0);
        send(16'sd3, 16'sd4, 1'b0);
        send(-16'sd5, 16'sd6, 1'b0);
        send(16'sd7, 16'sd8, 1'b1);
        send(16'sd2, 16'sd2, 1'b1);
        wait_out();
        check("group4_acc", out_acc, 40);
        check("group4_count", out_count, 4);
        wait_out();
        check("next_group_acc", out_acc, 4);
        check("next_group_count", out_count, 1);
        idle(2);

        send(-16'sd32768, -16'sd32768, 1'b1);
        wait_out();
        check("extreme_acc40", out_acc, 1073741824);
        check("extreme_acc32", out_acc32, 1073741824);
        idle(2);

        send(-16'sd32768, -16'sd32768, 1'b0);
        send(-16'sd32768, -16'sd32768, 1'b0);
        send(-16'sd32768, -16'sd32768, 1'b1);
        wait_out();
        check("ovf32_acc", out_acc32, SAT ? 64'sd2147483647 : -64'sd1073741824);
        check("ovf32_flag", out_ovf32, 1'b1);
        check("ovf32_count", out_count32, 3);
        check("ovf40_acc", out_acc, 64'sd3221225472);
        check("ovf40_flag", out_ovf, 1'b0);
        idle(2);

        out_ready = 1'b0;
        send(16'sd5, 16'sd5, 1'b1);
        send(16'sd6, 16'sd6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("bp_in_ready_low", in_ready, 1'b0);
            check("bp_valid_held", out_valid, 1'b1);
            check("bp_acc_stable", out_acc, 25);
        end
        out_ready = 1'b1;
        idle(1);
        check("bp_second_valid", out_valid, 1'b1);
        check("bp_second_acc", out_acc, 36);
        idle(2);

        send(16'sd7, 16'sd7, 1'b0);
        send(16'sd8, 16'sd8, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 1'b0);
        send(16'sd2, 16'sd3, 1'b1);
        wait_out();
        check("midrst_acc", out_acc, 6);
        check("midrst_count", out_count, 1);
        check("midrst_ovf", out_ovf, 1'b0);
        idle(2);

        pend = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!pend && $urandom_range(3) != 0) begin
                pend = 1'b1;
                in_a = pick();
                in_b = pick();
                in_last = ($urandom_range(3) == 0);
            end
            in_valid = pend;
            out_ready = ($urandom_range(3) != 0);
            #1;
            ok = pend && in_ready;
            @(posedge clk);
            #1;
            if (ok)
                pend = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(1);
        send(16'sd1, 16'sd1, 1'b1);
        idle(10);
        check("drain_q40_empty", q40.size(), 0);
        check("drain_q32_empty", q32.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
